// File: rtl/avmm_cmd_master.sv
// avmm_cmd_master
//   Avalon-MM master engine. Commands queue in a small FIFO and go out on the
//   bus one at a time, holding each request until the slave drops waitrequest.
//   Reads may be pipelined. Read data returns, in order, through a response
//   FIFO that is credit-protected so it can never overflow.
//
// Optional feature (macro AVMM_TIMEOUT_EN):
//   A request stalled by waitrequest for TIMEOUT_CYCLES cycles is abandoned.
//   An abandoned read returns all-ones data flagged with rsp_err.
//   Without the macro, timeout_err and rsp_err are tied low and err_clr is
//   ignored.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_*                 command push port (valid/ready), write/addr/be/wdata
//   rsp_*                 read response port (valid/ready), rdata, err flag
//   avmm_*                Avalon-MM master bus
//   busy                  command queued, request on bus, or read outstanding
//   timeout_err, err_clr  sticky timeout flag and its clear
module avmm_cmd_master #(
  parameter int ADDR_WIDTH      = 17,
  parameter int AVMM_WIDTH      = 32,
  parameter int BYTE_WIDTH      = 4,
  parameter int CMD_DEPTH       = 4,
  parameter int RSP_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT_CYCLES  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [BYTE_WIDTH-1:0] cmd_be,
  input  logic [AVMM_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [AVMM_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] avmm_address,
  output logic                  avmm_read,
  output logic                  avmm_write,
  output logic [AVMM_WIDTH-1:0] avmm_writedata,
  output logic [BYTE_WIDTH-1:0] avmm_byteenable,
  input  logic [AVMM_WIDTH-1:0] avmm_readdata,
  input  logic                  avmm_readdatavalid,
  input  logic                  avmm_waitrequest,
  output logic                  busy,
  output logic                  timeout_err,
  input  logic                  err_clr
);

  localparam int CMD_AW = $clog2(CMD_DEPTH);
  localparam int RSP_AW = $clog2(RSP_DEPTH);
  localparam int OUT_W  = $clog2(RSP_DEPTH + 1);
  localparam int SUM_W  = RSP_AW + 3;
  localparam logic [CMD_AW:0] CMD_ONE = 1;
  localparam logic [RSP_AW:0] RSP_ONE = 1;
  localparam logic [OUT_W-1:0] OUT_ONE = 1;

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t                state_q;
  logic                  avmmRead_q, avmmWrite_q;
  logic [ADDR_WIDTH-1:0] avmmAddr_q;
  logic [AVMM_WIDTH-1:0] avmmData_q;
  logic [BYTE_WIDTH-1:0] avmmBe_q;

  logic                  cmdWrite_q [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] cmdAddr_q  [CMD_DEPTH];
  logic [BYTE_WIDTH-1:0] cmdBe_q    [CMD_DEPTH];
  logic [AVMM_WIDTH-1:0] cmdData_q  [CMD_DEPTH];
  logic [CMD_AW:0]       cmdWrPtr_q, cmdRdPtr_q;
  logic                  cmdEmpty, cmdFull, cmdPush, cmdPop;
  logic                  headWrite;
  logic [ADDR_WIDTH-1:0] headAddr;
  logic [BYTE_WIDTH-1:0] headBe;
  logic [AVMM_WIDTH-1:0] headData;

  logic [AVMM_WIDTH-1:0] rspData_q [RSP_DEPTH];
  logic [RSP_AW:0]       rspWrPtr_q, rspWrPtr_d, rspRdPtr_q, rspCount;
  logic [RSP_AW-1:0]     rspIdx0, rspIdx1, rspErrIdx;
  logic                  rspPop, pushData, pushErr;

  logic [OUT_W-1:0]      outstanding_q, outstanding_d;
  logic [SUM_W-1:0]      pendingReads, creditUsed;
  logic                  readCredit, headIssuable, busAccept, abandon;

  // Command FIFO flags and head entry; the extra pointer bit separates full from empty.
  assign cmdEmpty  = (cmdWrPtr_q == cmdRdPtr_q);
  assign cmdFull   = (cmdWrPtr_q[CMD_AW] != cmdRdPtr_q[CMD_AW]) &&
                     (cmdWrPtr_q[CMD_AW-1:0] == cmdRdPtr_q[CMD_AW-1:0]);
  assign cmd_ready = !cmdFull;
  assign cmdPush   = cmd_valid && !cmdFull;
  assign headWrite = cmdWrite_q[cmdRdPtr_q[CMD_AW-1:0]];
  assign headAddr  = cmdAddr_q[cmdRdPtr_q[CMD_AW-1:0]];
  assign headBe    = cmdBe_q[cmdRdPtr_q[CMD_AW-1:0]];
  assign headData  = cmdData_q[cmdRdPtr_q[CMD_AW-1:0]];

  // A read sitting on the bus is counted as already outstanding: when the
  // next head is evaluated at that read's accept edge it must see the credit
  // that read is about to consume.
  assign busAccept    = (avmmRead_q || avmmWrite_q) && !avmm_waitrequest;
  assign pendingReads = SUM_W'(outstanding_q) + SUM_W'(avmmRead_q);
  assign creditUsed   = pendingReads + SUM_W'(rspCount);
  assign readCredit   = (pendingReads < SUM_W'(MAX_OUTSTANDING)) &&
                        (creditUsed < SUM_W'(RSP_DEPTH));
  assign headIssuable = !cmdEmpty && (headWrite || readCredit);
  assign cmdPop       = headIssuable && !abandon && ((state_q == IDLE) || busAccept);

  // Returned data is only believed while reads are outstanding, so stale
  // readdatavalid after a reset is dropped.
  assign pushData = avmm_readdatavalid && (outstanding_q != '0);
  assign pushErr  = abandon && avmmRead_q;

  assign rspCount  = rspWrPtr_q - rspRdPtr_q;
  assign rsp_valid = (rspWrPtr_q != rspRdPtr_q);
  assign rspPop    = rsp_valid && rsp_ready;
  assign rsp_rdata = rsp_valid ? rspData_q[rspRdPtr_q[RSP_AW-1:0]] : '0;
  assign rspIdx0   = rspWrPtr_q[RSP_AW-1:0];
  assign rspIdx1   = rspIdx0 + 1'b1;
  assign rspErrIdx = pushData ? rspIdx1 : rspIdx0;

  assign avmm_read       = avmmRead_q;
  assign avmm_write      = avmmWrite_q;
  assign avmm_address    = avmmAddr_q;
  assign avmm_writedata  = avmmData_q;
  assign avmm_byteenable = avmmBe_q;
  assign busy = !cmdEmpty || avmmRead_q || avmmWrite_q || (outstanding_q != '0);

  // Outstanding count and response write pointer. A read data return and an
  // abandoned read can land on the same edge, so up to two entries are pushed.
  always_comb begin
    outstanding_d = outstanding_q;
    if (busAccept && avmmRead_q) outstanding_d = outstanding_d + OUT_ONE;
    if (pushData)                outstanding_d = outstanding_d - OUT_ONE;
    rspWrPtr_d = rspWrPtr_q;
    if (pushData) rspWrPtr_d = rspWrPtr_d + RSP_ONE;
    if (pushErr)  rspWrPtr_d = rspWrPtr_d + RSP_ONE;
  end

  // FIFO storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (cmdPush) begin
      cmdWrite_q[cmdWrPtr_q[CMD_AW-1:0]] <= cmd_write;
      cmdAddr_q[cmdWrPtr_q[CMD_AW-1:0]]  <= cmd_addr;
      cmdBe_q[cmdWrPtr_q[CMD_AW-1:0]]    <= cmd_be;
      cmdData_q[cmdWrPtr_q[CMD_AW-1:0]]  <= cmd_wdata;
    end
    if (pushData) rspData_q[rspIdx0]   <= avmm_readdata;
    if (pushErr)  rspData_q[rspErrIdx] <= '1;
  end

  // Pointers and outstanding counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmdWrPtr_q    <= '0;
      cmdRdPtr_q    <= '0;
      rspWrPtr_q    <= '0;
      rspRdPtr_q    <= '0;
      outstanding_q <= '0;
    end else begin
      if (cmdPush) cmdWrPtr_q <= cmdWrPtr_q + CMD_ONE;
      if (cmdPop)  cmdRdPtr_q <= cmdRdPtr_q + CMD_ONE;
      if (rspPop)  rspRdPtr_q <= rspRdPtr_q + RSP_ONE;
      rspWrPtr_q    <= rspWrPtr_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Issue FSM with registered bus outputs. In ISSUE the request is held until
  // accepted; at the accept edge the next head is loaded directly when it is
  // issuable, giving back-to-back transfers without an idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      avmmRead_q  <= 1'b0;
      avmmWrite_q <= 1'b0;
      avmmAddr_q  <= '0;
      avmmData_q  <= '0;
      avmmBe_q    <= '0;
    end else begin
      if (cmdPop) begin
        state_q     <= ISSUE;
        avmmRead_q  <= !headWrite;
        avmmWrite_q <= headWrite;
        avmmAddr_q  <= headAddr;
        avmmData_q  <= headData;
        avmmBe_q    <= headBe;
      end else if ((state_q == ISSUE) && (busAccept || abandon)) begin
        state_q     <= IDLE;
        avmmRead_q  <= 1'b0;
        avmmWrite_q <= 1'b0;
      end
    end
  end

`ifdef AVMM_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_ONE = 1;

  logic            rspErr_q [RSP_DEPTH];
  logic [TO_W-1:0] toCnt_q, toCnt_d;
  logic            timeoutErr_q, reqStalled;

  // Stall counter: runs while a request is held off, restarts on every accept
  // or abandon. Abandon happens on the edge where the count already stands
  // at TIMEOUT_CYCLES.
  assign reqStalled = (avmmRead_q || avmmWrite_q) && avmm_waitrequest;
  assign abandon    = reqStalled && (toCnt_q == TO_W'(TIMEOUT_CYCLES));
  assign timeout_err = timeoutErr_q;
  assign rsp_err     = rsp_valid ? rspErr_q[rspRdPtr_q[RSP_AW-1:0]] : 1'b0;

  always_comb begin
    toCnt_d = '0;
    if (reqStalled && !abandon) toCnt_d = toCnt_q + TO_ONE;
  end

  // Error flag beside each response entry.
  always_ff @(posedge clk) begin
    if (pushData) rspErr_q[rspIdx0]   <= 1'b0;
    if (pushErr)  rspErr_q[rspErrIdx] <= 1'b1;
  end

  // Sticky timeout flag; a new timeout wins over a clear on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toCnt_q      <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      toCnt_q <= toCnt_d;
      if (abandon)      timeoutErr_q <= 1'b1;
      else if (err_clr) timeoutErr_q <= 1'b0;
    end
  end
`else
  logic unusedErrClr;

  assign unusedErrClr = err_clr;
  assign abandon      = 1'b0;
  assign timeout_err  = 1'b0;
  assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_avmm_cmd_master.sv
// Testbench for avmm_cmd_master: random and directed command streams against
// a behavioural memory model, with a bus scoreboard checked by a slave model
// and a response scoreboard checked by a separate monitor.
module tb_avmm_cmd_master;

  localparam int AW   = 17;
  localparam int DW   = 32;
  localparam int BW   = 4;
  localparam int MAXO = 2;
`ifdef AVMM_TIMEOUT_EN
  localparam int TOC = 8;
`else
  localparam int TOC = 256;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [BW-1:0] cmd_be;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] avmm_address;
  logic          avmm_read, avmm_write;
  logic [DW-1:0] avmm_writedata, avmm_readdata;
  logic [BW-1:0] avmm_byteenable;
  logic          avmm_readdatavalid, avmm_waitrequest;
  logic          busy, timeout_err, err_clr;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] data;
  } busOp_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          err;
  } rsp_t;
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } ret_t;

  busOp_t        expBus[$];
  rsp_t          expRsp[$];
  ret_t          slaveRet[$];
  logic [DW-1:0] refMem[int];
  logic [DW-1:0] slaveMem[int];

  int testsRun = 0;
  int testsFailed = 0;
  int cycle = 0;
  int stallMode = 0;
  int stallLeft = 0;
  int fixedLat = 0;
  int holdRsp = 0;
  int readAccepts = 0;
  int writeAccepts = 0;
  int benchOut = 0;
  int consecStall = 0;

  avmm_cmd_master #(
    .ADDR_WIDTH(AW), .AVMM_WIDTH(DW), .BYTE_WIDTH(BW), .CMD_DEPTH(4),
    .RSP_DEPTH(4), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .avmm_address(avmm_address), .avmm_read(avmm_read), .avmm_write(avmm_write),
    .avmm_writedata(avmm_writedata), .avmm_byteenable(avmm_byteenable),
    .avmm_readdata(avmm_readdata), .avmm_readdatavalid(avmm_readdatavalid),
    .avmm_waitrequest(avmm_waitrequest),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Memory contents before any write: a fixed scramble of the address.
  function automatic logic [DW-1:0] initVal(int a);
    return 32'h5A00_0000 ^ (a * 32'h0001_0203);
  endfunction

  function automatic logic [DW-1:0] mergeBe(logic [DW-1:0] old, logic [DW-1:0] nw,
                                            logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] refRead(int a);
    if (refMem.exists(a)) return refMem[a];
    return initVal(a);
  endfunction

  function automatic logic [DW-1:0] slaveRead(int a);
    if (slaveMem.exists(a)) return slaveMem[a];
    return initVal(a);
  endfunction

  task automatic reportFail(input string name, input string msg);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: %s", name, msg);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issue one command; the reference model executes commands in push order,
  // so expected read data is simply the model memory at push time.
  task automatic applyStimulus(input logic w, input logic [AW-1:0] a,
                               input logic [BW-1:0] be, input logic [DW-1:0] d);
    busOp_t op;
    rsp_t   r;
    int     guard;
    guard = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_be    = be;
    cmd_wdata = d;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) begin
      reportFail("cmdReadyWait", "cmd_ready stayed 0 for 500 cycles");
      cmd_valid = 1'b0;
      return;
    end
    op.write = w;
    op.addr  = a;
    op.be    = be;
    op.data  = d;
    expBus.push_back(op);
    if (w) begin
      refMem[int'(a)] = mergeBe(refRead(int'(a)), d, be);
    end else begin
      r.data = refRead(int'(a));
      r.err  = 1'b0;
      expRsp.push_back(r);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait for the bus side to go quiet, then for all responses to be drained.
  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((expBus.size() != 0 || slaveRet.size() != 0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) reportFail({tag, "BusDrain"}, "bus traffic did not complete in 3000 cycles");
    @(negedge clk);
    checkOutput({tag, "BusyFall"}, busy, 0);
    guard = 0;
    while (expRsp.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) reportFail({tag, "RspDrain"}, $sformatf("%0d responses never arrived", expRsp.size()));
    @(negedge clk);
    checkOutput({tag, "RspEmpty"}, rsp_valid, 0);
  endtask

  // Slave model: drives waitrequest and in-order read returns; checks every
  // accepted request against the expected bus sequence.
  initial begin
    busOp_t e;
    ret_t   r;
    logic   wq;
    avmm_waitrequest   = 1'b0;
    avmm_readdatavalid = 1'b0;
    avmm_readdata      = '0;
    forever begin
      @(negedge clk);
      avmm_readdatavalid = 1'b0;
      avmm_readdata      = $urandom;
      if (!rst_n) begin
        avmm_waitrequest = 1'b0;
        continue;
      end
      if (slaveRet.size() > 0 && slaveRet[0].due <= cycle) begin
        r = slaveRet.pop_front();
        avmm_readdatavalid = 1'b1;
        avmm_readdata      = r.data;
        if (benchOut > 0) benchOut--;
      end
      if (avmm_read || avmm_write) begin
        checkOutput("rwExclusive", {63'd0, avmm_read & avmm_write}, 0);
        if (stallLeft > 0) begin
          wq = 1'b1;
          stallLeft--;
        end else if (stallMode == 2) wq = 1'b1;
        else if (stallMode == 1)     wq = 1'b0;
        else wq = (consecStall < 3) && ($urandom_range(0, 3) == 0);
        consecStall = wq ? consecStall + 1 : 0;
        avmm_waitrequest = wq;
        if (!wq) begin
          if (expBus.size() == 0) begin
            reportFail("unexpectedBusOp", $sformatf("got op at 0x%0h, expected none", avmm_address));
          end else begin
            e = expBus.pop_front();
            checkOutput("busWrite", avmm_write, e.write);
            checkOutput("busAddr", avmm_address, e.addr);
            checkOutput("busBe", avmm_byteenable, e.be);
            if (e.write) checkOutput("busWdata", avmm_writedata, e.data);
          end
          if (avmm_write) begin
            writeAccepts++;
            slaveMem[int'(avmm_address)] = mergeBe(slaveRead(int'(avmm_address)),
                                                   avmm_writedata, avmm_byteenable);
          end else begin
            readAccepts++;
            benchOut++;
            checkOutput("outstandingLimit", {63'd0, benchOut > MAXO}, 0);
            r.data = slaveRead(int'(avmm_address));
            r.due  = cycle + ((fixedLat != 0) ? fixedLat : $urandom_range(1, 4));
            slaveRet.push_back(r);
          end
        end
      end else begin
        avmm_waitrequest = $urandom_range(0, 1) != 0;
        consecStall = 0;
      end
    end
  end

  // Response monitor: pops the expected queue on every consumed response.
  initial begin
    rsp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = (holdRsp == 0) && ($urandom_range(0, 3) != 0);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (expRsp.size() == 0) begin
          reportFail("unexpectedRsp", $sformatf("got rdata 0x%0h, expected no response", rsp_rdata));
        end else begin
          e = expRsp.pop_front();
          checkOutput("rspData", rsp_rdata, e.data);
          checkOutput("rspErr", rsp_err, e.err);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int base;
    int guard;
    logic [AW-1:0] a;
    rsp_t er;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_be    = '0;
    cmd_wdata = '0;
    err_clr   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("rstCmdReady", cmd_ready, 1);
    checkOutput("rstRspValid", rsp_valid, 0);
    checkOutput("rstRead", avmm_read, 0);
    checkOutput("rstWrite", avmm_write, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstTimeoutErr", timeout_err, 0);
    checkOutput("rstRdata", rsp_rdata, 0);
    checkOutput("rstAddr", avmm_address, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, no stall: one bus cycle, starting the edge after the push
    stallMode = 1;
    applyStimulus(1'b1, 17'h1_0004, 4'hF, 32'hCAFE_F00D);
    checkOutput("wrNotEarly", avmm_write, 0);
    @(negedge clk);
    checkOutput("wrHigh", avmm_write, 1);
    checkOutput("wrAddr", avmm_address, 17'h1_0004);
    checkOutput("wrData", avmm_writedata, 32'hCAFE_F00D);
    checkOutput("wrBe", avmm_byteenable, 4'hF);
    @(negedge clk);
    checkOutput("wrOneCycle", avmm_write, 0);
    drain("write1");

    // Write held off by waitrequest for 3 cycles
    base = writeAccepts;
    stallLeft = 3;
    applyStimulus(1'b1, 17'h0_0010, 4'h3, 32'h1234_5678);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avmm_write) begin
        cnt++;
        checkOutput("stallAddr", avmm_address, 17'h0_0010);
        checkOutput("stallData", avmm_writedata, 32'h1234_5678);
        checkOutput("stallBe", avmm_byteenable, 4'h3);
      end else if (cnt > 0) break;
    end
    checkOutput("stallCycles", cnt, 4);
    checkOutput("stallAccepts", writeAccepts - base, 1);
    drain("stallWr");

    // Four back-to-back reads, fixed 2-cycle read latency
    fixedLat = 2;
    applyStimulus(1'b0, 17'h1_0004, 4'hF, $urandom);
    applyStimulus(1'b0, 17'h0_0010, 4'hF, $urandom);
    applyStimulus(1'b0, 17'h0_0003, 4'hF, $urandom);
    applyStimulus(1'b0, 17'h1_0004, 4'h5, $urandom);
    drain("pipeRd");
    fixedLat = 0;

    // Response credit: with rsp_ready held low only 4 of 6 reads may issue
    stallMode = 0;
    holdRsp = 1;
    base = readAccepts;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 17'($urandom_range(0, 7)), 4'hF, $urandom);
    repeat (60) @(negedge clk);
    checkOutput("creditIssued", readAccepts - base, 4);
    checkOutput("creditRspValid", rsp_valid, 1);
    checkOutput("creditBusy", busy, 1);
    holdRsp = 0;
    drain("credit");
    checkOutput("creditAllIssued", readAccepts - base, 6);

    // Reset with one read outstanding and a second stalled on the bus
    stallMode = 1;
    fixedLat = 30;
    applyStimulus(1'b0, 17'h0_0005, 4'hF, $urandom);
    guard = 0;
    while (benchOut == 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) reportFail("rstFirstRead", "first read was never accepted");
    stallMode = 2;
    applyStimulus(1'b0, 17'h0_0006, 4'hF, $urandom);
    guard = 0;
    while (!avmm_read && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rstStalledRead", avmm_read, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstAsyncRead", avmm_read, 0);
    checkOutput("rstAsyncBusy", busy, 0);
    expBus.delete();
    expRsp.delete();
    benchOut = 0;
    @(negedge clk);
    rst_n = 1'b1;
    stallMode = 1;
    repeat (50) @(negedge clk);
    checkOutput("lateRdvIgnored", rsp_valid, 0);
    checkOutput("lateRdvBusy", busy, 0);
    checkOutput("lateRetConsumed", slaveRet.size(), 0);
    fixedLat = 0;

`ifdef AVMM_TIMEOUT_EN
    // Read stuck behind waitrequest is abandoned with an error response
    stallMode = 2;
    applyStimulus(1'b0, 17'h0_0007, 4'hF, $urandom);
    void'(expBus.pop_back());
    void'(expRsp.pop_back());
    er.data = '1;
    er.err  = 1'b1;
    expRsp.push_back(er);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (avmm_read) cnt++;
      else if (cnt > 0) break;
    end
    checkOutput("toStallWindow", {63'd0, (cnt >= TOC) && (cnt <= TOC + 1)}, 1);
    stallMode = 1;
    checkOutput("toErrSet", timeout_err, 1);
    drain("timeout");
    checkOutput("toErrSticky", timeout_err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("toErrCleared", timeout_err, 0);
`else
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checkOutput("noToErr", timeout_err, 0);
`endif

    // Randomised mixed traffic over a small address set
    stallMode = 0;
    for (int i = 0; i < 300; i++) begin
      a = 17'($urandom_range(0, 7));
      if ($urandom_range(0, 1) != 0) a[16] = 1'b1;
      applyStimulus(1'($urandom_range(0, 1)), a, 4'($urandom_range(1, 15)), $urandom);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
    end
    drain("random");
    checkOutput("endCmdReady", cmd_ready, 1);
    checkOutput("endTimeoutErr", timeout_err, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/avmm_cmd_master.md
Name: avmm_cmd_master

Overview:
- Parametrised Avalon-MM master engine; successor to the DV-side Avalon-MM interface driver, implemented as synthesisable RTL.
- Accepts queued read/write commands on a valid/ready port and issues them on an Avalon-MM bus, honouring waitrequest.
- Supports pipelined reads (multiple outstanding) and returns read data in order through a response FIFO.
- Sits between the AIB configuration sequencer and the per-channel Avalon-MM CSR fabric.

Parameters:
ADDR_WIDTH, 17, Avalon address width
AVMM_WIDTH, 32, data width; must be multiple of 8
BYTE_WIDTH, 4, byteenable width; must equal AVMM_WIDTH/8
CMD_DEPTH, 4, command FIFO entries; power of 2, >=2
RSP_DEPTH, 4, response FIFO entries; power of 2, >=2
MAX_OUTSTANDING, 2, max issued-but-unreturned reads; 1..RSP_DEPTH
TIMEOUT_CYCLES, 256, waitrequest timeout; used only with AVMM_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command FIFO not full
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  command address
cmd_be  in  BYTE_WIDTH  byte enables
cmd_wdata  in  AVMM_WIDTH  write data
rsp_valid  out  1  read response available
rsp_ready  in  1  response consumed
rsp_rdata  out  AVMM_WIDTH  read data
rsp_err  out  1  response is a timed-out read
avmm_address  out  ADDR_WIDTH  bus address
avmm_read  out  1  bus read
avmm_write  out  1  bus write
avmm_writedata  out  AVMM_WIDTH  bus write data
avmm_byteenable  out  BYTE_WIDTH  bus byte enables
avmm_readdata  in  AVMM_WIDTH  bus read data
avmm_readdatavalid  in  1  bus read data valid
avmm_waitrequest  in  1  slave stall
busy  out  1  any command queued, issuing, or read outstanding
timeout_err  out  1  sticky timeout flag
err_clr  in  1  clears timeout_err

Behaviour:
- Reset: all outputs 0 except cmd_ready, which is 1. FIFOs empty, outstanding count 0, FSM IDLE. Assertion is asynchronous; deassertion is synchronous to clk.
- Reset mid-operation: bus request drops immediately; outstanding reads are forgotten; any later readdatavalid is ignored.
- Command push: on cmd_valid & cmd_ready at an edge. cmd_ready = !cmd_fifo_full.
- FSM IDLE:
  - Pops the FIFO head when it is non-empty and issue is allowed.
  - Writes are always allowed.
  - Reads are allowed only if outstanding < MAX_OUTSTANDING and (outstanding + rsp_count) < RSP_DEPTH (credit rule; the response FIFO can never overflow).
  - On pop, drives avmm_* registered from the head and moves to ISSUE.
- FSM ISSUE:
  - Holds address, data, byteenable, read and write stable while avmm_waitrequest=1.
  - At an edge with waitrequest=0 the request is accepted.
  - If the next head is issuable, it is driven at the same edge (back-to-back, no bubble); otherwise read/write deassert and the FSM returns to IDLE.
- Latency: a command pushed at edge E into an empty FIFO on an idle engine appears on the bus from edge E+1.
- Read accepted: outstanding += 1.
- avmm_readdatavalid: pushes avmm_readdata to the response FIFO with rsp_err=0 and decrements outstanding.
  - Same-edge accept and return: outstanding unchanged.
  - readdatavalid with outstanding=0 is ignored.
- Response port: rsp_valid = !rsp_fifo_empty. Pop on rsp_valid & rsp_ready. A simultaneous push and pop on a full FIFO is legal.
- busy = !cmd_fifo_empty | avmm_read | avmm_write | (outstanding != 0).
- avmm_read and avmm_write are never both 1.

Optional Feature:
- Macro AVMM_TIMEOUT_EN.
- Defined:
  - Counter increments each cycle a request is asserted with waitrequest=1, and clears on accept.
  - When the count reaches TIMEOUT_CYCLES, the request is abandoned next edge: read/write deassert and timeout_err is set.
  - An abandoned read pushes a response with rsp_rdata = all-ones and rsp_err=1; its credit is consumed as for a normal read.
  - timeout_err clears on err_clr=1. Set wins over clear on the same edge.
- Undefined: no counter; timeout_err and rsp_err are tied 0; err_clr is ignored.

Test Plan:
- Write 0x1_0004, be=4'hF, wdata=0xCAFE_F00D, waitrequest=0 -> avmm_write high exactly 1 cycle, from the edge after the push, with matching address/data/be; no response.
- Same write with waitrequest held 3 cycles -> avmm_* stable for 4 cycles; single acceptance.
- 4 back-to-back reads; slave returns data 2 cycles after accept; MAX_OUTSTANDING=2 -> never more than 2 outstanding; responses returned in order; busy falls after the last return.
- RSP_DEPTH=4, rsp_ready=0, 6 reads queued -> only 4 issued; the remaining 2 issue only after rsp_ready pops entries.
- rst_n pulsed low while a read is outstanding and waitrequest=1 -> avmm_read drops asynchronously; late readdatavalid is ignored; no response.
- AVMM_TIMEOUT_EN, TIMEOUT_CYCLES=8, read with waitrequest stuck high -> abandoned after 8 stalled cycles; rsp_err=1 with rdata 0xFFFF_FFFF; timeout_err set and cleared by err_clr.
